// File: rtl/tcb_argmax_stream.sv
`default_nettype none
// ============================================================================
// Module   : tcb_argmax_stream
// Brief    : Streaming argmax over a packed score vector, LANES scores/cycle,
//            with a one-entry pending buffer for back-to-back images.
// Revision : 1.0 - initial release
// ============================================================================
module tcb_argmax_stream #(
    parameter int N_CLASS = 10,
    parameter int SCORE_W = 28,
    parameter int LANES   = 1,
    parameter int SIGNED  = 1,
    parameter int OUT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CLASS*SCORE_W-1:0] layer_out,
    input  logic                       valid,
    output logic [OUT_W-1:0]           predict,
    output logic [SCORE_W-1:0]         max_score,
    output logic                       ready,
    output logic                       full,
    output logic                       overflow
);

    localparam int c_NB     = (N_CLASS + LANES - 1) / LANES;
    localparam int c_IDX_W  = $clog2(N_CLASS);
    localparam int c_BEAT_W = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam int c_SPAN   = c_NB * LANES;
    localparam int c_BASE_W = $clog2(c_SPAN + 1);
    localparam int c_WORK_W = c_SPAN * SCORE_W;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_NB - 1);
    localparam logic [c_BASE_W-1:0] c_N_CLASS   = c_BASE_W'(N_CLASS);
    localparam logic [c_BASE_W-1:0] c_LANES     = c_BASE_W'(LANES);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]                 r_state;
    logic [0:0]                 w_state_nxt;
    logic [c_BEAT_W-1:0]        r_beat;
    logic [c_BASE_W-1:0]        r_base;
    logic [c_WORK_W-1:0]        r_work;
    logic [N_CLASS*SCORE_W-1:0] r_pend;
    logic                       r_full;
    logic                       r_overflow;
    logic [c_IDX_W-1:0]         r_best_idx;
    logic [SCORE_W-1:0]         r_best_val;
    logic [OUT_W-1:0]           r_predict;
    logic [SCORE_W-1:0]         r_max_score;
    logic                       r_ready;

    logic [c_IDX_W-1:0]         w_best_idx;
    logic [SCORE_W-1:0]         w_best_val;
    logic [c_BASE_W-1:0]        w_lane_idx;
    logic [SCORE_W-1:0]         w_lane_val;
    logic                       w_last;

    function automatic logic f_gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        else             return a > b;
    endfunction

    assign w_last = (r_beat == c_LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (valid) w_state_nxt = S_SCAN;
            S_SCAN:  if (w_last && !r_full && !valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The work register is shifted down each beat, so the current lanes
    // always sit in the low slots; r_base tracks their original index.
    always_comb begin
        w_best_idx = (r_beat == '0) ? '0 : r_best_idx;
        w_best_val = (r_beat == '0) ? r_work[SCORE_W-1:0] : r_best_val;
        w_lane_idx = '0;
        w_lane_val = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_idx = r_base + c_BASE_W'(l);
            w_lane_val = r_work[l*SCORE_W +: SCORE_W];
            if ((w_lane_idx < c_N_CLASS) && f_gt(w_lane_val, w_best_val)) begin
                w_best_idx = c_IDX_W'(w_lane_idx);
                w_best_val = w_lane_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat      <= '0;
            r_base      <= '0;
            r_work      <= '0;
            r_pend      <= '0;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_best_idx  <= '0;
            r_best_val  <= '0;
            r_predict   <= '0;
            r_max_score <= '0;
            r_ready     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_work <= c_WORK_W'(layer_out);
                        r_beat <= '0;
                        r_base <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_last) begin
                        r_predict   <= OUT_W'(w_best_idx);
                        r_max_score <= w_best_val;
                        r_ready     <= 1'b1;
                        r_beat      <= '0;
                        r_base      <= '0;
                        // Pending image has priority; a simultaneous new one refills pending.
                        if (r_full) begin
                            r_work <= c_WORK_W'(r_pend);
                            if (valid) r_pend <= layer_out;
                            else       r_full <= 1'b0;
                        end else if (valid) begin
                            r_work <= c_WORK_W'(layer_out);
                        end
                    end else begin
                        r_beat     <= r_beat + 1'b1;
                        r_base     <= r_base + c_LANES;
                        r_work     <= r_work >> (LANES * SCORE_W);
                        r_best_idx <= w_best_idx;
                        r_best_val <= w_best_val;
                        if (valid) begin
                            if (!r_full) begin
                                r_pend <= layer_out;
                                r_full <= 1'b1;
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign predict   = r_predict;
    assign max_score = r_max_score;
    assign ready     = r_ready;
    assign full      = r_full;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
